bulls_cows_engine: RTL
======================

BULLS_COWS_ENGINE -- requirements
Module: bulls_cows_engine

Interface
REQ-001 The module SHALL have these parameters (name, default, meaning):
- N_DIGITS, 4: digits per secret/guess.
- DIGIT_W, 4: bits per digit.
- DIGIT_MAX, 9: largest legal digit value; N_DIGITS <= DIGIT_MAX+1.
- N_PLAYERS, 2: players, >= 2.
- SCORE_W, 8: bits per player score.
REQ-002 Derived widths SHALL be PW = max(1, clog2(N_PLAYERS)) and CW = clog2(N_DIGITS+1).
REQ-003 The module SHALL have these ports (name, direction, width, meaning):
- clock, in, 1: rising-edge clock.
- reset, in, 1: asynchronous, active-high reset.
- guess, in, N_DIGITS*DIGIT_W: digit i = guess[i*DIGIT_W +: DIGIT_W].
- confirm, in, 1: raw, unsynchronised push button.
- state, out, 2: 0 SETUP, 1 GUESS, 2 SHOW, 3 WIN.
- player, out, PW: active player index.
- bulls, out, CW: bulls count of the last accepted guess.
- cows, out, CW: cows count of the last accepted guess.
- reject, out, 1: one-cycle pulse when an entry is refused.
- tries, out, 8: accepted guesses this round.
- scores, out, N_PLAYERS*SCORE_W: score of player p = scores[p*SCORE_W +: SCORE_W].

Function
REQ-004 confirm SHALL pass through three flops s1 -> s2 -> s3; event = s2 & ~s3; the FSM SHALL act on an event at the clock edge that ends the event cycle.
REQ-005 An event SHALL be generated only on a 0->1 transition of s2; a held button SHALL yield exactly one event.
REQ-006 An entry SHALL be invalid when any digit > DIGIT_MAX or any two digits are equal; otherwise it is valid.
REQ-007 An invalid entry on an event SHALL pulse reject high for exactly one cycle and leave every other register unchanged.
REQ-008 SETUP, valid event: store guess as secret[player].
- If player < N_PLAYERS-1: player++.
- Otherwise: player <= 0 and state <= GUESS.
REQ-009 The target secret in GUESS SHALL be secret[(player+1) mod N_PLAYERS].
REQ-010 bulls SHALL be the count of i with guess digit i == target digit i.
REQ-011 cows SHALL be the count of i with guess digit i != target digit i and guess digit i == target digit j for some j != i.
REQ-012 GUESS, valid event:
- Register bulls and cows.
- tries++, saturating at 255.
- If bulls == N_DIGITS: state <= WIN and scores[player]++, saturating at 2^SCORE_W-1.
- Otherwise: state <= SHOW.
REQ-013 SHOW, any event: player <= (player+1) mod N_PLAYERS and state <= GUESS; guess validity SHALL be ignored and reject SHALL NOT fire.
REQ-014 WIN, any event:
- state <= SETUP and player <= 0.
- Clear bulls, cows, tries and all secrets.
- Retain scores.
REQ-015 bulls and cows SHALL hold their value until the next accepted guess, WIN exit, or reset.
REQ-016 Outputs SHALL be driven directly from registers; result latency SHALL be 1 cycle after the acting edge.
REQ-017 Events SHALL be ignored in any state while reset is high.

Reset
REQ-018 reset high SHALL immediately clear state, player, bulls, cows, reject, tries, scores and all secrets to 0.
REQ-019 reset SHALL set s1, s2 and s3 to 1, so a button held through reset release produces no event until it is released and pressed again.
REQ-020 Reset asserted mid-round (GUESS, SHOW or WIN) SHALL abandon the round with no score change beyond the clear in REQ-018.

Verification (default parameters)
REQ-021 Secrets 0x1234 (P0) and 0x5678 (P1); P0 guesses 0x8765 -> bulls 0, cows 4, state SHOW, tries 1, player 0.
REQ-022 Continue: event in SHOW -> player 1, GUESS; P1 guesses 0x1243 -> bulls 2, cows 2, SHOW, tries 2.
REQ-023 Continue: event, then P0 guesses 0x5678 -> bulls 4, state WIN, scores[0] = 1; event -> SETUP, player 0, tries 0, scores[0] still 1.
REQ-024 In SETUP, enter 0x1123, then 0x12A4 -> two one-cycle reject pulses; state SETUP and player 0 unchanged; then 0x1234 -> player 1.
REQ-025 Confirm held high for 20 cycles -> exactly one event, 3 edges after the first sampling edge.
REQ-026 Confirm high across reset release -> no event; after release and re-press -> one event.
REQ-027 Reset pulsed while in GUESS with scores[1] = 3 -> all outputs 0 before the next clock edge.

Source files
------------

// File: rtl/bulls_cows_engine.sv
// Bulls & cows game engine for N_PLAYERS players taking turns against each
// other's secrets. A raw push button is synchronised and edge-detected; each
// press advances the game FSM (SETUP -> GUESS <-> SHOW -> WIN -> SETUP).
//
// Ports:
//   clock   - rising-edge clock
//   reset   - asynchronous, active-high reset
//   guess   - N_DIGITS digits, digit i = guess[i*DIGIT_W +: DIGIT_W]
//   confirm - raw push button (unsynchronised)
//   state   - 0 SETUP, 1 GUESS, 2 SHOW, 3 WIN
//   player  - active player index
//   bulls   - bulls count of last accepted guess
//   cows    - cows count of last accepted guess
//   reject  - one-cycle pulse when an entry is refused
//   tries   - accepted guesses this round (saturating)
//   scores  - per-player score, player p = scores[p*SCORE_W +: SCORE_W]
module bulls_cows_engine #(
  parameter int unsigned N_DIGITS  = 4,
  parameter int unsigned DIGIT_W   = 4,
  parameter int unsigned DIGIT_MAX = 9,
  parameter int unsigned N_PLAYERS = 2,
  parameter int unsigned SCORE_W   = 8,
  localparam int unsigned PW = ($clog2(N_PLAYERS) > 1) ? $clog2(N_PLAYERS) : 1,
  localparam int unsigned CW = $clog2(N_DIGITS + 1),
  localparam int unsigned GW = N_DIGITS * DIGIT_W,
  localparam int unsigned TW = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [GW-1:0]                guess,
  input  logic                         confirm,
  output logic [1:0]                   state,
  output logic [PW-1:0]                player,
  output logic [CW-1:0]                bulls,
  output logic [CW-1:0]                cows,
  output logic                         reject,
  output logic [TW-1:0]                tries,
  output logic [N_PLAYERS*SCORE_W-1:0] scores
);

  typedef enum logic [1:0] {
    ST_SETUP = 2'd0,
    ST_GUESS = 2'd1,
    ST_SHOW  = 2'd2,
    ST_WIN   = 2'd3
  } state_e;

  state_e                       state_q, state_d;
  logic [PW-1:0]                player_q, player_d;
  logic [CW-1:0]                bulls_q, bulls_d;
  logic [CW-1:0]                cows_q, cows_d;
  logic                         reject_q, reject_d;
  logic [TW-1:0]                tries_q, tries_d;
  logic [N_PLAYERS*SCORE_W-1:0] scores_q, scores_d;
  logic [GW-1:0]                secret_q [N_PLAYERS];
  logic [GW-1:0]                secret_d [N_PLAYERS];

  logic                         s1_q, s2_q, s3_q;
  logic                         event_c;
  logic                         valid_c;
  logic                         hit_c;
  logic [PW-1:0]                player_nxt_c;
  logic [GW-1:0]                target_c;
  logic [CW-1:0]                bulls_c, cows_c;
  logic [SCORE_W-1:0]           cur_score_c;

  // Button synchroniser; flops reset high so a press held through reset is ignored
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      s3_q <= 1'b1;
    end else begin
      s1_q <= confirm;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign event_c = s2_q & ~s3_q;

  // Entry validity: every digit in range and all digits distinct
  always_comb begin
    valid_c = 1'b1;
    for (int i = 0; i < int'(N_DIGITS); i++) begin
      if (guess[i*DIGIT_W +: DIGIT_W] > DIGIT_W'(DIGIT_MAX)) valid_c = 1'b0;
      for (int j = i + 1; j < int'(N_DIGITS); j++) begin
        if (guess[i*DIGIT_W +: DIGIT_W] == guess[j*DIGIT_W +: DIGIT_W]) valid_c = 1'b0;
      end
    end
  end

  // The guesser attacks the next player's secret, wrapping around
  assign player_nxt_c = (player_q == PW'(N_PLAYERS - 1)) ? '0 : player_q + PW'(1);
  assign target_c     = secret_q[player_nxt_c];

  // Score of the current guess against the target secret
  always_comb begin
    bulls_c = '0;
    cows_c  = '0;
    hit_c   = 1'b0;
    for (int i = 0; i < int'(N_DIGITS); i++) begin
      hit_c = 1'b0;
      if (guess[i*DIGIT_W +: DIGIT_W] == target_c[i*DIGIT_W +: DIGIT_W]) begin
        bulls_c = bulls_c + CW'(1);
      end else begin
        for (int j = 0; j < int'(N_DIGITS); j++) begin
          if (j != i && guess[i*DIGIT_W +: DIGIT_W] == target_c[j*DIGIT_W +: DIGIT_W]) begin
            hit_c = 1'b1;
          end
        end
        if (hit_c) cows_c = cows_c + CW'(1);
      end
    end
  end

  assign cur_score_c = scores_q[player_q*SCORE_W +: SCORE_W];

  // Game FSM next-state and register updates
  always_comb begin
    state_d  = state_q;
    player_d = player_q;
    bulls_d  = bulls_q;
    cows_d   = cows_q;
    reject_d = 1'b0;
    tries_d  = tries_q;
    scores_d = scores_q;
    secret_d = secret_q;
    if (event_c) begin
      case (state_q)
        ST_SETUP: begin
          if (!valid_c) begin
            reject_d = 1'b1;
          end else begin
            secret_d[player_q] = guess;
            player_d           = player_nxt_c;
            if (player_q == PW'(N_PLAYERS - 1)) state_d = ST_GUESS;
          end
        end
        ST_GUESS: begin
          if (!valid_c) begin
            reject_d = 1'b1;
          end else begin
            bulls_d = bulls_c;
            cows_d  = cows_c;
            if (tries_q != {TW{1'b1}}) tries_d = tries_q + TW'(1);
            if (bulls_c == CW'(N_DIGITS)) begin
              state_d = ST_WIN;
              if (cur_score_c != {SCORE_W{1'b1}}) begin
                scores_d[player_q*SCORE_W +: SCORE_W] = cur_score_c + SCORE_W'(1);
              end
            end else begin
              state_d = ST_SHOW;
            end
          end
        end
        ST_SHOW: begin
          player_d = player_nxt_c;
          state_d  = ST_GUESS;
        end
        ST_WIN: begin
          state_d  = ST_SETUP;
          player_d = '0;
          bulls_d  = '0;
          cows_d   = '0;
          tries_d  = '0;
          for (int p = 0; p < int'(N_PLAYERS); p++) secret_d[p] = '0;
        end
        default: state_d = ST_SETUP;
      endcase
    end
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_SETUP;
      player_q <= '0;
      bulls_q  <= '0;
      cows_q   <= '0;
      reject_q <= 1'b0;
      tries_q  <= '0;
      scores_q <= '0;
      for (int p = 0; p < int'(N_PLAYERS); p++) secret_q[p] <= '0;
    end else begin
      state_q  <= state_d;
      player_q <= player_d;
      bulls_q  <= bulls_d;
      cows_q   <= cows_d;
      reject_q <= reject_d;
      tries_q  <= tries_d;
      scores_q <= scores_d;
      for (int p = 0; p < int'(N_PLAYERS); p++) secret_q[p] <= secret_d[p];
    end
  end

  assign state  = state_q;
  assign player = player_q;
  assign bulls  = bulls_q;
  assign cows   = cows_q;
  assign reject = reject_q;
  assign tries  = tries_q;
  assign scores = scores_q;

endmodule
